buffer_feeder: RTL and testbench

Upstream transmitter for the ping-pong bridge buffers. Accepts a single-word valid/ready stream, packs words into per-instance, per-lane west-bank write beats, and presents them with a one-cycle `in_valid_w` strobe. It counts beats up to one full tile (bank depth), then stalls until the downstream matmul signals the tile is consumed. It sits between the DMA/stream source and the west-bank write side of the buffer top.

---
 rtl/buffer_feeder_pkg.sv | 24 ++
 rtl/buffer_feeder.sv | 109 ++++++++++
 tb/tb_buffer_feeder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/buffer_feeder_pkg.sv
// Shared types and default sizing for the buffer feeder.
package buffer_feeder_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    WAIT = 2'd2
  } feeder_state_t;

  localparam int DEF_INSTANCES = 4;
  localparam int DEF_LANES     = 2;
  localparam int DEF_IN_WIDTH  = 64;
  localparam int DEF_DEPTH     = 16;

  localparam int WPB    = DEF_INSTANCES * DEF_LANES;
  localparam int SLOT_W = $clog2(WPB);
  localparam int BEAT_W = $clog2(DEF_DEPTH + 1);

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int v);
    return (v <= 1) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/buffer_feeder.sv
// Stream-to-west-bank packer: gathers WPB stream words into one write beat,
// strobes it for a cycle, and stalls after a full tile until released.
// Optional feature macro: BUFFER_FEEDER_ZERO_PAD_EN (s_last zero-pads the
// beat and ends the tile early).
module buffer_feeder
  import buffer_feeder_pkg::*;
#(
  parameter int NUMBER_OF_BUFFER_INSTANCES = DEF_INSTANCES,
  parameter int TOTAL_INPUT_W              = DEF_LANES,
  parameter int IN_WIDTH                   = DEF_IN_WIDTH,
  parameter int TOTAL_DEPTH                = DEF_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               s_valid,
  output logic                               s_ready,
  input  logic [IN_WIDTH-1:0]                s_data,
  input  logic                               s_last,
  input  logic                               release_tile,
  output logic [IN_WIDTH-1:0]                w_din [NUMBER_OF_BUFFER_INSTANCES][TOTAL_INPUT_W],
  output logic                               in_valid_w,
  output logic                               tile_full,
  output logic [$clog2(TOTAL_DEPTH+1)-1:0]   beat_cnt
);

  localparam int L_WPB    = NUMBER_OF_BUFFER_INSTANCES * TOTAL_INPUT_W;
  localparam int L_SLOT_W = clog2_min1(L_WPB);
  localparam int L_BEAT_W = $clog2(TOTAL_DEPTH + 1);
  localparam logic [L_SLOT_W-1:0] L_SLOT_MAX  = L_SLOT_W'(L_WPB - 1);
  localparam logic [L_BEAT_W-1:0] L_LAST_BEAT = L_BEAT_W'(TOTAL_DEPTH - 1);

  feeder_state_t         r_state, w_next;
  logic [L_SLOT_W-1:0]   r_slot;
  logic [L_BEAT_W-1:0]   r_beat;
  logic                  r_final;
  logic                  w_acc;
  logic                  w_last;
  logic                  w_beat_done;

  assign s_ready    = (r_state == FILL) && !rst;
  assign w_acc      = s_valid && s_ready;
  assign in_valid_w = (r_state == EMIT);
  assign tile_full  = (r_state == WAIT);
  assign beat_cnt   = r_beat;

`ifdef BUFFER_FEEDER_ZERO_PAD_EN
  assign w_last = w_acc && s_last;
`else
  // s_last has no effect without padding; tiles end on depth alone.
  assign w_last = 1'b0 & s_last;
`endif

  assign w_beat_done = w_acc && ((r_slot == L_SLOT_MAX) || w_last);

  // Pack register: each slot captures its word; a short last word zeroes the tail.
  for (genvar gi = 0; gi < NUMBER_OF_BUFFER_INSTANCES; gi++) begin : g_inst
    for (genvar gj = 0; gj < TOTAL_INPUT_W; gj++) begin : g_lane
      localparam logic [L_SLOT_W-1:0] K = L_SLOT_W'(gi * TOTAL_INPUT_W + gj);
      logic [IN_WIDTH-1:0] r_din;

      // Slot write: data on its own slot, zero on tail slots after s_last.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_din <= '0;
        else if (w_acc && (K == r_slot))  r_din <= s_data;
        else if (w_last && (K > r_slot))  r_din <= '0;
      end

      assign w_din[gi][gj] = r_din;
    end
  end

  // Slot counter wraps at each completed beat; final-beat flag for early tile end.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_slot  <= '0;
      r_final <= 1'b0;
    end else if (w_beat_done) begin
      r_slot  <= '0;
      r_final <= w_last;
    end else if (w_acc) begin
      r_slot  <= r_slot + 1'b1;
    end
  end

  // Beat counter: bumps on every emit, cleared when the tile is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                   r_beat <= '0;
    else if (r_state == EMIT)                  r_beat <= r_beat + 1'b1;
    else if ((r_state == WAIT) && release_tile) r_beat <= '0;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= FILL;
    else     r_state <= w_next;
  end

  // Next state: release only matters once the tile has been closed.
  always_comb begin
    w_next = r_state;
    case (r_state)
      FILL:    if (w_beat_done) w_next = EMIT;
      EMIT:    w_next = ((r_beat == L_LAST_BEAT) || r_final) ? WAIT : FILL;
      WAIT:    if (release_tile) w_next = FILL;
      default: w_next = FILL;
    endcase
  end

endmodule

// File: tb/tb_buffer_feeder.sv
// Scoreboard bench for buffer_feeder: expected beats are queued as words are
// accepted and compared whenever in_valid_w fires.
module tb_buffer_feeder;

  localparam int NI  = 4;
  localparam int NL  = 2;
  localparam int W   = 64;
  localparam int D   = 16;
  localparam int WPB = NI * NL;

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid;
  logic          s_ready;
  logic [W-1:0]  s_data;
  logic          s_last;
  logic          release_tile;
  logic [W-1:0]  w_din [NI][NL];
  logic          in_valid_w;
  logic          tile_full;
  logic [4:0]    beat_cnt;

  buffer_feeder #(
    .NUMBER_OF_BUFFER_INSTANCES(NI),
    .TOTAL_INPUT_W(NL),
    .IN_WIDTH(W),
    .TOTAL_DEPTH(D)
  ) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .release_tile(release_tile),
    .w_din(w_din), .in_valid_w(in_valid_w), .tile_full(tile_full),
    .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;
  int n_pulse = 0;
  int last_acc = 0;
  int pulse_cyc[$];
  logic [WPB*W-1:0] sb[$];
  logic [W-1:0] mdl [WPB];
  int mslot = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [WPB*W-1:0] pack_mdl();
    logic [WPB*W-1:0] v;
    for (int k = 0; k < WPB; k++) v[k*W +: W] = mdl[k];
    return v;
  endfunction

  // Compare each emitted beat against the oldest queued expectation.
  always @(negedge clk) begin
    if (in_valid_w) begin
      logic [WPB*W-1:0] e;
      n_pulse++;
      pulse_cyc.push_back(cyc);
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        for (int k = 0; k < WPB; k++)
          chk($sformatf("beat_w%0d", k), w_din[k/NL][k%NL], e[k*W +: W]);
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < WPB; k++) mdl[k] = '0;
    mslot = 0;
  endtask

  // Offer one word after 'gap' idle cycles (optionally toggling release_tile
  // during the idle cycles); returns one tick after the accepting edge.
  task automatic send(input logic [W-1:0] d, input bit last, input int gap, input bit rel_noise);
    bit acc;
    int n;
    bit last_eff;
    for (int g = 0; g < gap; g++) begin
      s_valid = 1'b0;
      s_data = {$urandom, $urandom};
      release_tile = rel_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
    end
    release_tile = 1'b0;
    s_valid = 1'b1;
    s_data = d;
    s_last = last;
    acc = 1'b0;
    n = 0;
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk); #1;
      n++;
    end
    if (!acc) chk("send_timeout", 64'(acc), 64'd1);
    last_acc = cyc;
    s_valid = 1'b0;
    s_last = 1'b0;
    s_data = {$urandom, $urandom};
`ifdef BUFFER_FEEDER_ZERO_PAD_EN
    last_eff = last;
`else
    last_eff = 1'b0;
`endif
    if (acc) begin
      mdl[mslot] = d;
      if (last_eff)
        for (int k = mslot + 1; k < WPB; k++) mdl[k] = '0;
      mslot++;
      if (mslot == WPB || last_eff) begin
        sb.push_back(pack_mdl());
        mslot = 0;
      end
    end
  endtask

  task automatic pulse_release();
    release_tile = 1'b1;
    @(posedge clk); #1;
    release_tile = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0;
    logic [W-1:0] orv;
    rst = 1'b1;
    s_valid = 1'b1;
    s_data = 64'hDEAD_BEEF_0123_4567;
    s_last = 1'b0;
    release_tile = 1'b0;
    for (int k = 0; k < WPB; k++) mdl[k] = '0;

    // Reset held with a valid word offered.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_in_valid", 64'(in_valid_w), 64'd0);
    chk("rst_tile_full", 64'(tile_full), 64'd0);
    chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
    orv = '0;
    for (int k = 0; k < WPB; k++) orv = orv | w_din[k/NL][k%NL];
    chk("rst_w_din", orv, 64'd0);
    @(posedge clk); #1;
    s_valid = 1'b0;
    rst = 1'b0;

    // Single beat 0x10..0x17.
    for (int k = 0; k < WPB; k++) send(64'(8'h10 + k), 1'b0, 0, 1'b0);
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("sb_pulses", 64'(n_pulse), 64'd1);
    if (pulse_cyc.size() != 0) chk("sb_latency", 64'(pulse_cyc[0]), 64'(last_acc));
    chk("sb_w00", w_din[0][0], 64'h10);
    chk("sb_w01", w_din[0][1], 64'h11);
    chk("sb_w31", w_din[3][1], 64'h17);
    chk("sb_beat_cnt", 64'(beat_cnt), 64'd1);
    chk("sb_in_valid_low", 64'(in_valid_w), 64'd0);

    // Full tile; a release during the final emit must be ignored.
    @(posedge clk); #1;
    do_reset();
    pulse_cyc.delete();
    p0 = n_pulse;
    for (int k = 0; k < D * WPB; k++) send(64'(32'h1000 + k), 1'b0, 0, 1'b0);
    pulse_release();
    @(negedge clk);
    chk("ft_pulses", 64'(n_pulse - p0), 64'(D));
    chk("ft_tile_full", 64'(tile_full), 64'd1);
    chk("ft_s_ready", 64'(s_ready), 64'd0);
    chk("ft_beat_cnt", 64'(beat_cnt), 64'(D));
    for (int i = 1; i < pulse_cyc.size(); i++)
      chk($sformatf("ft_spacing%0d", i), 64'(pulse_cyc[i] - pulse_cyc[i-1]), 64'd9);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("ft_still_full", 64'(tile_full), 64'd1);
    @(posedge clk); #1;
    pulse_release();
    @(negedge clk);
    chk("rel_s_ready", 64'(s_ready), 64'd1);
    chk("rel_tile_full", 64'(tile_full), 64'd0);
    chk("rel_beat_cnt", 64'(beat_cnt), 64'd0);
    @(posedge clk); #1;

    // One clean beat, then a gapped beat with release noise in FILL.
    p0 = n_pulse;
    for (int k = 0; k < WPB; k++) send(64'(16'h2000 + k), 1'b0, 0, 1'b0);
    for (int k = 0; k < WPB; k++)
      send({$urandom, $urandom}, 1'b0, int'($urandom_range(0, 3)), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("gap_pulses", 64'(n_pulse - p0), 64'd2);
    chk("gap_beat_cnt", 64'(beat_cnt), 64'd2);

    // Mid-beat reset discards the partial beat.
    @(posedge clk); #1;
    p0 = n_pulse;
    for (int k = 0; k < 5; k++) send(64'(16'h3300 + k), 1'b0, 0, 1'b0);
    do_reset();
    @(negedge clk);
    chk("mr_no_pulse", 64'(n_pulse - p0), 64'd0);
    chk("mr_beat_cnt", 64'(beat_cnt), 64'd0);
    @(posedge clk); #1;
    for (int k = 0; k < WPB; k++) send(64'(16'h4400 + k), 1'b0, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mr_pulses", 64'(n_pulse - p0), 64'd1);
    chk("mr_beat_cnt1", 64'(beat_cnt), 64'd1);

`ifdef BUFFER_FEEDER_ZERO_PAD_EN
    // Short last beat: zero-padded tail and early tile end.
    @(posedge clk); #1;
    do_reset();
    p0 = n_pulse;
    send(64'h30, 1'b0, 0, 1'b0);
    send(64'h31, 1'b0, 0, 1'b0);
    send(64'h32, 1'b1, 0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("pad_pulses", 64'(n_pulse - p0), 64'd1);
    chk("pad_tile_full", 64'(tile_full), 64'd1);
    chk("pad_beat_cnt", 64'(beat_cnt), 64'd1);
    @(posedge clk); #1;
    pulse_release();
`endif

    @(negedge clk);
    chk("sb_drain", 64'(sb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
